// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the primary-memory port arbiter
package mem_pkg;

  localparam int MEM_AW = 16;
  localparam int MEM_DW = 16;
  localparam logic [MEM_AW-1:0] XFR_WIN_BASE = 16'd49152;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_XFR  = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN_CPU = 2'd1,
    ST_OWN_XFR = 2'd2,
    ST_TURN    = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

  // On a tie the requester that did not own the port last goes first.
  function automatic arb_state_t pick_owner(input logic cpu_req, input logic xfr_req,
                                            input owner_t last_owner);
    if (cpu_req && xfr_req) return (last_owner == OWN_CPU) ? ST_OWN_XFR : ST_OWN_CPU;
    else if (cpu_req)       return ST_OWN_CPU;
    else if (xfr_req)       return ST_OWN_XFR;
    else                    return ST_IDLE;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// rtl/rd_tag_pipe.sv - shift register tracking which requester issued each in-flight read
module rd_tag_pipe
  import mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t pipe_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin, burst-bounded arbiter sharing the primary memory
// port between the CPU and the block-transfer engine, with tagged read return.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int AW        = MEM_AW,
  parameter int DW        = MEM_DW,
  parameter int MAX_BURST = 4,
  parameter int RD_LAT    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          xfr_req,
  input  logic          xfr_we,
  input  logic [AW-1:0] xfr_addr,
  input  logic [DW-1:0] xfr_wdata,
  output logic          xfr_gnt,
  output logic          xfr_rvalid,
  output logic [DW-1:0] xfr_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  arb_state_t    state_q, state_d;
  owner_t        last_owner_q, last_owner_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d, cnt_inc;
  logic          cpu_gnt_q, xfr_gnt_q;
  logic          cpu_acc, xfr_acc;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_data_q, cpu_rdata_q, xfr_rdata_q;
  logic          mem_wren_q, cpu_rvalid_q, xfr_rvalid_q;
  rd_tag_t       push_tag, ret_tag;

  assign cpu_acc = cpu_gnt_q & cpu_req;
  assign xfr_acc = xfr_gnt_q & xfr_req;
  assign cnt_inc = (burst_cnt_q == CNT_MAX) ? CNT_MAX : burst_cnt_q + CW'(1);

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    unique case (state_q)
      ST_IDLE, ST_TURN: state_d = pick_owner(cpu_req, xfr_req, last_owner_q);
      ST_OWN_CPU: begin
        // The burst limit only bites when the other side is actually waiting.
        if (!cpu_req || (cnt_inc == CNT_MAX && xfr_req)) begin
          state_d      = ST_TURN;
          last_owner_d = OWN_CPU;
          burst_cnt_d  = '0;
        end else begin
          burst_cnt_d  = cnt_inc;
        end
      end
      ST_OWN_XFR: begin
        if (!xfr_req || (cnt_inc == CNT_MAX && cpu_req)) begin
          state_d      = ST_TURN;
          last_owner_d = OWN_XFR;
          burst_cnt_d  = '0;
        end else begin
          burst_cnt_d  = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWN_XFR;
      burst_cnt_q  <= '0;
      cpu_gnt_q    <= 1'b0;
      xfr_gnt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      cpu_gnt_q    <= (state_d == ST_OWN_CPU);
      xfr_gnt_q    <= (state_d == ST_OWN_XFR);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_wren_q <= 1'b0;
    end else if (cpu_acc) begin
      mem_addr_q <= cpu_addr;
      mem_data_q <= cpu_wdata;
      mem_wren_q <= cpu_we;
    end else if (xfr_acc) begin
      mem_addr_q <= xfr_addr;
      mem_data_q <= xfr_wdata;
      mem_wren_q <= xfr_we;
    end else begin
      mem_wren_q <= 1'b0;
    end
  end

  always_comb begin
    push_tag.valid = (cpu_acc & ~cpu_we) | (xfr_acc & ~xfr_we);
    push_tag.owner = cpu_acc ? OWN_CPU : (xfr_acc ? OWN_XFR : OWN_NONE);
  end

  // One stage per cycle of memory latency plus the address register stage.
  rd_tag_pipe #(.DEPTH(RD_LAT + 1)) u_rd_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (push_tag),
    .tag_o (ret_tag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rvalid_q <= 1'b0;
      xfr_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      xfr_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= ret_tag.valid && (ret_tag.owner == OWN_CPU);
      xfr_rvalid_q <= ret_tag.valid && (ret_tag.owner == OWN_XFR);
      if (ret_tag.valid && ret_tag.owner == OWN_CPU) cpu_rdata_q <= mem_q;
      if (ret_tag.valid && ret_tag.owner == OWN_XFR) xfr_rdata_q <= mem_q;
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign xfr_gnt    = xfr_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign xfr_rvalid = xfr_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign xfr_rdata  = xfr_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_wren   = mem_wren_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, xfr_req, xfr_we;
  logic [15:0] cpu_addr, cpu_wdata, xfr_addr, xfr_wdata;

  logic        cpu_gnt, cpu_rvalid, xfr_gnt, xfr_rvalid, mem_wren;
  logic [15:0] cpu_rdata, xfr_rdata, mem_addr, mem_data, mem_q;
  logic        d3_cpu_gnt, d3_cpu_rvalid, d3_xfr_gnt, d3_xfr_rvalid, d3_mem_wren;
  logic [15:0] d3_cpu_rdata, d3_xfr_rdata, d3_mem_addr, d3_mem_data, d3_mem_q;

  logic [15:0] m1_q;
  logic [15:0] m3_pipe [3];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(16), .DW(16), .MAX_BURST(4), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .xfr_req(xfr_req), .xfr_we(xfr_we), .xfr_addr(xfr_addr), .xfr_wdata(xfr_wdata),
    .xfr_gnt(xfr_gnt), .xfr_rvalid(xfr_rvalid), .xfr_rdata(xfr_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  mem_port_arbiter #(.AW(16), .DW(16), .MAX_BURST(4), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(d3_cpu_gnt), .cpu_rvalid(d3_cpu_rvalid), .cpu_rdata(d3_cpu_rdata),
    .xfr_req(xfr_req), .xfr_we(xfr_we), .xfr_addr(xfr_addr), .xfr_wdata(xfr_wdata),
    .xfr_gnt(d3_xfr_gnt), .xfr_rvalid(d3_xfr_rvalid), .xfr_rdata(d3_xfr_rdata),
    .mem_addr(d3_mem_addr), .mem_data(d3_mem_data), .mem_wren(d3_mem_wren), .mem_q(d3_mem_q)
  );

  // Memory contents are addr ^ 0x5A5A, delivered after 1 or 3 register stages.
  always @(posedge clk) begin
    m1_q       <= mem_addr ^ 16'h5A5A;
    m3_pipe[0] <= d3_mem_addr ^ 16'h5A5A;
    m3_pipe[1] <= m3_pipe[0];
    m3_pipe[2] <= m3_pipe[1];
  end
  assign mem_q    = m1_q;
  assign d3_mem_q = m3_pipe[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    xfr_req = 0; xfr_we = 0; xfr_addr = 0; xfr_wdata = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [101:0] outs;
    logic         seen;
    do_reset();
    outs = {cpu_gnt, xfr_gnt, cpu_rvalid, xfr_rvalid, mem_wren, cpu_rdata, xfr_rdata,
            mem_addr, mem_data, 32'h0};
    n_cmp++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs); end
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
    tick();
    tick(); cpu_addr = 16'h0101;
    tick();
    rst = 1'b1;
    #1;
    outs = {cpu_gnt, xfr_gnt, cpu_rvalid, xfr_rvalid, mem_wren, cpu_rdata, xfr_rdata,
            mem_addr, mem_data, 32'h0};
    n_cmp++;
    if (outs !== '0) begin n_fail++; $display("FAIL async_reset_outputs: got %h want 0", outs); end
    cpu_req = 0;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen |= cpu_rvalid | xfr_rvalid;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL dropped_read_rvalid: got %b want 0", seen); end
    cpu_req = 1; xfr_req = 1;
    tick();
    n_cmp++;
    if ({cpu_gnt, xfr_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL reset_tie_grant: got %b want 10", {cpu_gnt, xfr_gnt});
    end
  endtask

  task automatic test_cpu_read();
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    tick();
    n_cmp++;
    if ({cpu_gnt, xfr_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL cpu_read_gnt: got %b want 10", {cpu_gnt, xfr_gnt});
    end
    tick();
    n_cmp++;
    if ({mem_addr, mem_wren} !== {16'h0010, 1'b0}) begin
      n_fail++; $display("FAIL cpu_read_addr0: got %h/%b want 0010/0", mem_addr, mem_wren);
    end
    cpu_addr = 16'h0011;
    tick();
    n_cmp++;
    if ({mem_addr, cpu_rvalid} !== {16'h0011, 1'b0}) begin
      n_fail++; $display("FAIL cpu_read_addr1: got %h/%b want 0011/0", mem_addr, cpu_rvalid);
    end
    cpu_req = 0;
    tick();
    n_cmp++;
    if ({cpu_rvalid, cpu_rdata, cpu_gnt} !== {1'b1, 16'h5A4A, 1'b0}) begin
      n_fail++; $display("FAIL cpu_read_ret0: got %b/%h/%b want 1/5a4a/0", cpu_rvalid, cpu_rdata, cpu_gnt);
    end
    tick();
    n_cmp++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 16'h5A4B}) begin
      n_fail++; $display("FAIL cpu_read_ret1: got %b/%h want 1/5a4b", cpu_rvalid, cpu_rdata);
    end
    tick();
    n_cmp++;
    if ({cpu_rvalid, cpu_rdata, xfr_rvalid, xfr_rdata, xfr_gnt} !== {1'b0, 16'h5A4B, 1'b0, 16'h0, 1'b0}) begin
      n_fail++; $display("FAIL cpu_read_after: got %b/%h/%b/%h/%b want 0/5a4b/0/0000/0",
                         cpu_rvalid, cpu_rdata, xfr_rvalid, xfr_rdata, xfr_gnt);
    end
  endtask

  task automatic test_xfr_write();
    logic seen;
    do_reset();
    xfr_req = 1; xfr_we = 1; xfr_addr = 16'hC000; xfr_wdata = 16'hA5A0;
    tick();
    n_cmp++;
    if ({cpu_gnt, xfr_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL xfr_write_gnt: got %b want 01", {cpu_gnt, xfr_gnt});
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      xfr_addr  = 16'hC000 + 16'(i);
      xfr_wdata = 16'hA5A0 + 16'(i);
      tick();
      seen |= cpu_rvalid | xfr_rvalid;
      n_cmp++;
      if ({mem_wren, mem_addr, mem_data} !== {1'b1, 16'hC000 + 16'(i), 16'hA5A0 + 16'(i)}) begin
        n_fail++; $display("FAIL xfr_write_beat%0d: got %b/%h/%h want 1/%h/%h", i, mem_wren,
                           mem_addr, mem_data, 16'hC000 + 16'(i), 16'hA5A0 + 16'(i));
      end
    end
    xfr_req = 0;
    tick();
    n_cmp++;
    if ({mem_wren, mem_addr} !== {1'b0, 16'hC002}) begin
      n_fail++; $display("FAIL xfr_write_end: got %b/%h want 0/c002", mem_wren, mem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      seen |= cpu_rvalid | xfr_rvalid;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL xfr_write_rvalid: got %b want 0", seen); end
  endtask

  task automatic test_burst_alternation();
    logic [1:0] exp_gnt;
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0001;
    xfr_req = 1; xfr_we = 0; xfr_addr = 16'hC001;
    for (int k = 0; k < 14; k++) begin
      if (k < 4)       exp_gnt = 2'b10;
      else if (k == 4) exp_gnt = 2'b00;
      else if (k < 9)  exp_gnt = 2'b01;
      else if (k == 9) exp_gnt = 2'b00;
      else             exp_gnt = 2'b10;
      tick();
      n_cmp++;
      if ({cpu_gnt, xfr_gnt} !== exp_gnt) begin
        n_fail++; $display("FAIL burst_gnt_cycle%0d: got %b want %b", k, {cpu_gnt, xfr_gnt}, exp_gnt);
      end
    end
    cpu_req = 0; xfr_req = 0;
  endtask

  task automatic test_cross_owner();
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
    tick();
    tick();
    cpu_req = 0;
    xfr_req = 1; xfr_we = 0; xfr_addr = 16'hC000;
    tick();
    tick();
    n_cmp++;
    if ({cpu_rvalid, cpu_rdata, xfr_rvalid, xfr_gnt} !== {1'b1, 16'h5A7A, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL cross_cpu_ret: got %b/%h/%b/%b want 1/5a7a/0/1",
                         cpu_rvalid, cpu_rdata, xfr_rvalid, xfr_gnt);
    end
    tick();
    xfr_req = 0;
    n_cmp++;
    if ({cpu_rvalid, xfr_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL cross_gap: got %b want 00", {cpu_rvalid, xfr_rvalid});
    end
    tick();
    tick();
    n_cmp++;
    if ({xfr_rvalid, xfr_rdata, cpu_rvalid, cpu_rdata} !== {1'b1, 16'h9A5A, 1'b0, 16'h5A7A}) begin
      n_fail++; $display("FAIL cross_xfr_ret: got %b/%h/%b/%h want 1/9a5a/0/5a7a",
                         xfr_rvalid, xfr_rdata, cpu_rvalid, cpu_rdata);
    end
    tick();
    n_cmp++;
    if ({cpu_rvalid, xfr_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL cross_after: got %b want 00", {cpu_rvalid, xfr_rvalid});
    end
  endtask

  task automatic test_back_to_back_lat3();
    logic        exp_v;
    logic [15:0] exp_d;
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0030;
    tick();
    exp_d = 16'h0;
    for (int e = 2; e <= 10; e++) begin
      tick();
      if (e <= 5) begin
        n_cmp++;
        if (d3_mem_addr !== 16'h0030 + 16'(e - 2)) begin
          n_fail++; $display("FAIL lat3_addr_edge%0d: got %h want %h", e, d3_mem_addr, 16'h0030 + 16'(e - 2));
        end
        if (e < 5) cpu_addr = 16'h0030 + 16'(e - 1);
        else       cpu_req = 0;
      end
      exp_v = (e >= 6 && e <= 9);
      if (exp_v) exp_d = (16'h0030 + 16'(e - 6)) ^ 16'h5A5A;
      n_cmp++;
      if ({d3_cpu_rvalid, d3_cpu_rdata} !== {exp_v, exp_d}) begin
        n_fail++; $display("FAIL lat3_ret_edge%0d: got %b/%h want %b/%h", e, d3_cpu_rvalid,
                           d3_cpu_rdata, exp_v, exp_d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_xfr_write();
    test_burst_alternation();
    test_cross_owner();
    test_back_to_back_lat3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  // Never both grants at once, on either instance.
  always @(negedge clk) begin
    if (!rst && ((cpu_gnt && xfr_gnt) || (d3_cpu_gnt && d3_xfr_gnt))) begin
      n_cmp++;
      n_fail++;
      $display("FAIL dual_grant: got both high want at most one");
    end
  end

endmodule
